// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The optional parity stage is selected with the UART_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Register offsets, selected by byte-address bits [3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // Assemble the STATUS read word
    function automatic logic [31:0] pack_status(input logic ovf, input logic busy,
                                                input logic empty, input logic full);
        logic [31:0] s;
        s = '0;
        s[ST_OVF]   = ovf;
        s[ST_BUSY]  = busy;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous show-ahead FIFO used as the UART transmit queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still taken
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Read and write pointers; power-of-two depth makes them wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, registers and 8N1 serialiser.
// Defining UART_PARITY_EN inserts an even-parity bit (8E1 frames).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DIV_RESET = 16'd433,
    parameter int          ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [3:0]        byteEnable,
    input  logic [ADDR_W-1:0] a,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              tx
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]       reg_sel;
    logic             wr_cycle;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    logic [15:0] div_reg;
    logic        ovf_reg;
    logic [31:0] rd_reg;

    tx_state_t   state_reg,   state_next;
    logic [15:0] cnt_reg,     cnt_next;
    logic [15:0] bit_div_reg, bit_div_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg,   shift_next;
    logic        tx_reg,      tx_next;
    logic        bit_end;
`ifdef UART_PARITY_EN
    logic        parity_reg,  parity_next;
`endif

    assign reg_sel     = a[3:2];
    assign wr_cycle    = sel & we;
    assign fifo_push   = wr_cycle & byteEnable[0] & (reg_sel == REG_TXDATA);
    assign bit_end     = (cnt_reg == bit_div_reg);
    assign rd          = rd_reg;
    assign tx          = tx_reg;
    assign unused_bits = ^{wd[31:16], a, byteEnable[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read data mux for the addressed register
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: rd_mux = pack_status(ovf_reg, state_reg != IDLE, fifo_empty, fifo_full);
            REG_DIV:    rd_mux = {16'b0, div_reg};
            REG_LEVEL:  rd_mux = {{(32 - CNT_W){1'b0}}, fifo_count};
            default:    rd_mux = '0;
        endcase
    end

    // Register file: divisor bytes, sticky overflow and registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_RESET;
            ovf_reg <= 1'b0;
            rd_reg  <= '0;
        end else begin
            if (wr_cycle && reg_sel == REG_DIV) begin
                if (byteEnable[0]) div_reg[7:0]  <= wd[7:0];
                if (byteEnable[1]) div_reg[15:8] <= wd[15:8];
            end
            // A dropped byte in the same cycle as a clear leaves the flag set
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_reg <= 1'b1;
            end else if (wr_cycle && byteEnable[0] && reg_sel == REG_STATUS && wd[ST_OVF]) begin
                ovf_reg <= 1'b0;
            end
            if (sel && !we) begin
                rd_reg <= rd_mux;
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_div_reg <= DIV_RESET;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
`ifdef UART_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_div_reg <= bit_div_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
`ifdef UART_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // Serialiser next state; tx is computed one cycle ahead so it leaves a flop
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_div_next = bit_div_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;
`ifdef UART_PARITY_EN
        parity_next  = parity_reg;
`endif
        // Bit timing; the period is re-sampled from div only at bit boundaries
        if (bit_end) begin
            cnt_next     = '0;
            bit_div_next = div_reg;
        end else begin
            cnt_next = cnt_reg + 16'd1;
        end
        case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
        // Load the next byte from IDLE, or straight out of STOP with no idle gap
        if ((state_reg == IDLE || (state_reg == STOP && bit_end)) && !fifo_empty) begin
            fifo_pop     = 1'b1;
            shift_next   = fifo_dout;
            state_next   = START;
            tx_next      = 1'b0;
            cnt_next     = '0;
            bit_div_next = div_reg;
`ifdef UART_PARITY_EN
            parity_next  = ^fifo_dout;
`endif
        end
    end

endmodule
